// File: rtl/data_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_mem_responder : word-addressed data memory behind valid/ready request
//                      and response channels, fixed access latency, one
//                      outstanding request, per-byte write strobes.
// Revision: 1.0
// ----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_SIZE   = 1024,
   parameter int LATENCY    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    resp_err
);

   localparam int c_nbytes = DATA_WIDTH / 8;
   localparam int c_idx_w  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam int c_cnt_w  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [c_cnt_w-1:0]    c_cnt_load = c_cnt_w'(LATENCY - 1);
   localparam logic [c_cnt_w-1:0]    c_cnt_one  = c_cnt_w'(1);
   localparam logic [ADDR_WIDTH-1:0] c_mem_size = ADDR_WIDTH'(MEM_SIZE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [c_cnt_w-1:0]      r_cnt;
   logic [c_cnt_w-1:0]      w_cnt_next;
   logic                    w_accept;
   logic                    w_access;
   logic                    w_in_range;
   logic [c_idx_w-1:0]      w_idx;

   logic                    r_write;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [c_nbytes-1:0]     r_wstrb;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic                    r_err;

   logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];

   // Full-width compare so out-of-range addresses never alias into the array.
   assign w_in_range = (r_addr < c_mem_size);
   assign w_idx      = r_addr[c_idx_w-1:0];

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      w_access     = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_accept     = 1'b1;
               w_cnt_next   = c_cnt_load;
               w_state_next = BUSY;
            end
         end
         BUSY: begin
            if (r_cnt != '0) begin
               w_cnt_next = r_cnt - c_cnt_one;
            end else begin
               w_access     = 1'b1;
               w_state_next = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else if (w_accept) begin
         r_write <= req_write;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_wstrb <= req_wstrb;
      end
   end

   // Response payload is captured once at the access edge and held through RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_access) begin
         r_err   <= ~w_in_range;
         r_rdata <= (!r_write && w_in_range) ? mem[w_idx] : '0;
      end
   end

   // Storage is never reset; w_access is state-derived so a reset in BUSY cancels the write.
   always_ff @(posedge clk) begin
      if (w_access && r_write && w_in_range) begin
         for (int i = 0; i < c_nbytes; i++) begin
            if (r_wstrb[i]) begin
               mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

   assign req_ready  = (r_state == IDLE);
   assign resp_valid = (r_state == RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Multi-cycle data-memory responder that serves load/store requests from the core's memory stage over a valid/ready request channel and a valid/ready response channel. It replaces the combinational data memory for pipelined and out-of-order cores, modelling a fixed access latency with back-pressure. It allows one outstanding request, is word-addressed, and has per-byte write strobes.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 32, width of the word address.
MEM_SIZE, 1024, number of words stored; valid addresses are 0..MEM_SIZE-1.
LATENCY, 2, cycles from request acceptance to response valid; must be at least 1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_write  input  1  1 = store, 0 = load.
req_addr  input  ADDR_WIDTH  word address.
req_wdata  input  DATA_WIDTH  store data.
req_wstrb  input  DATA_WIDTH/8  byte enables for a store; bit i enables byte i.
resp_valid  output  1  response present.
resp_ready  input  1  requester accepts the response.
resp_rdata  output  DATA_WIDTH  load data; 0 for stores and for errors.
resp_err  output  1  address was out of range (>= MEM_SIZE).

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- States:
  - IDLE: req_ready=1, resp_valid=0.
  - BUSY: req_ready=0, resp_valid=0.
  - RESP: req_ready=0, resp_valid=1.
- Reset (asynchronous):
  - State goes to IDLE; the latency counter goes to 0.
  - resp_rdata=0, resp_err=0, so resp_valid=0 and req_ready=1.
  - Storage array is not reset; contents persist.
- Accept: handshake is req_valid && req_ready at a rising edge in IDLE.
  - Latch write, addr, wdata and wstrb.
  - Load counter with LATENCY-1 and go to BUSY.
  - req_* inputs are ignored outside IDLE.
- BUSY:
  - If the counter is nonzero, decrement it.
  - If the counter is 0, perform the access on that edge and go to RESP.
  - Result: for acceptance at edge E, resp_valid rises after edge E+LATENCY.
- Access, in range:
  - Load: resp_rdata = mem[addr], resp_err = 0.
  - Store: write each byte i where wstrb[i]=1; other bytes are unchanged. resp_rdata = 0, resp_err = 0.
  - Store with wstrb all-zero: no memory change; normal response.
- Access, out of range (addr >= MEM_SIZE, full ADDR_WIDTH compare, no wrap or alias):
  - No memory change.
  - resp_rdata = 0, resp_err = 1.
- RESP:
  - resp_rdata and resp_err are held stable while resp_valid=1 && resp_ready=0.
  - On resp_ready=1, go to IDLE at that edge.
  - A new request cannot be accepted in the same cycle as the response handshake. Minimum issue interval is LATENCY+2 cycles.
- Ordering: a load accepted after a store's response sees the stored data.
- Reset mid-operation:
  - A store still in BUSY when rst asserts is not committed.
  - A store already in RESP is committed.
  - Any pending response is dropped.
- Outputs are registered or derived from state only; there is no combinational path from req_* or resp_ready to any output.

Test Plan:
- Reset: assert rst asynchronously between edges -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 immediately, without waiting for a clock edge.
- Latency timing, LATENCY=3: store 0xDEADBEEF to addr 5 with wstrb=4'hF, then load addr 5 -> each resp_valid rises exactly 3 edges after its accept edge; the load returns 0xDEADBEEF with resp_err=0.
- Byte strobes: store 0xFFFFFFFF to addr 7, then store 0x12345678 with wstrb=4'b0101, then load addr 7 -> 0xFF34FF78.
- Back-pressure: hold resp_ready=0 for 5 cycles in RESP while req_valid=1 -> resp_rdata stays stable, req_ready=0, no second request is accepted; release resp_ready -> IDLE on the next edge.
- Out of range: store to addr 1024 (MEM_SIZE=1024), then load addr 1024 -> both return resp_err=1 and resp_rdata=0; a load of addr 0 is unchanged.
- Reset during BUSY: store 0xAAAA5555 to addr 3 (previously 0), assert rst one cycle after accept with LATENCY=3 -> after reset a load of addr 3 returns 0.
